// File: rtl/sha256_pkg.sv
// Shared SHA-256 memory-responder types: word width, defaults, FSM states, byte swap helper.
package sha256_pkg;

    localparam int SHA_WORD_W             = 32;
    localparam int SHA_MEM_DEPTH_LOG2_DEF = 10;
    localparam int SHA_MEM_RD_LAT_DEF     = 2;

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } sha_mem_state_e;

    function automatic logic [SHA_WORD_W-1:0] sha_bswap32(input logic [SHA_WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha_mem_responder_if.sv
// Fetch-read and host-write bus of the SHA message memory; slave = responder, master = fetcher/host.
interface sha_mem_responder_if
    import sha256_pkg::*;
#(
    parameter int DEPTH_LOG2 = SHA_MEM_DEPTH_LOG2_DEF
) ();

    logic                  mem_addr_vld;
    logic [31:0]           mem_addr;
    logic                  mem_data_vld;
    logic [SHA_WORD_W-1:0] mem_data;
    logic                  wr_vld;
    logic                  wr_rdy;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [SHA_WORD_W-1:0] wr_data;
    logic                  init_done;
    logic                  oob_err;

    modport slave (
        input  mem_addr_vld, mem_addr, wr_vld, wr_addr, wr_data,
        output mem_data_vld, mem_data, wr_rdy, init_done, oob_err
    );

    modport master (
        output mem_addr_vld, mem_addr, wr_vld, wr_addr, wr_data,
        input  mem_data_vld, mem_data, wr_rdy, init_done, oob_err
    );

endinterface

// File: rtl/sha_mem_array.sv
// Single-port word RAM, one read or write per cycle, registered read data (1-cycle latency).
// No backpressure; contents are never reset.
module sha_mem_array #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sha_mem_responder.sv
// SHA message-fetch memory responder: zeroes RAM after reset, then serves in-order reads READ_LATENCY cycles
// after request (no read backpressure); host writes only when no read is issued. SHA_MEM_BYTESWAP_EN byte-reverses responses.
module sha_mem_responder
    import sha256_pkg::*;
#(
    parameter int DEPTH_LOG2   = SHA_MEM_DEPTH_LOG2_DEF,
    parameter int READ_LATENCY = SHA_MEM_RD_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    sha_mem_responder_if.slave  bus
);

    localparam logic [DEPTH_LOG2-1:0] CNT_MAX = '1;

    sha_mem_state_e        state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;

    logic                  s1_vld_q;
    logic                  s1_zero_q;
    logic                  oob_err_q;

    logic                  ram_en;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [SHA_WORD_W-1:0] ram_wdata;
    logic [SHA_WORD_W-1:0] ram_rdata;

    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  oob_hit;
    logic                  wr_fire;
    logic [SHA_WORD_W-1:0] s1_word;
    logic [SHA_WORD_W-1:0] s1_dat;
    logic                  unused_addr_lsb;

    assign rd_idx          = bus.mem_addr[DEPTH_LOG2+1:2];
    assign oob_hit         = (bus.mem_addr >> (DEPTH_LOG2 + 2)) != '0;
    assign unused_addr_lsb = ^bus.mem_addr[1:0];

    // Reads own the single RAM port; the host only gets it on idle SERVE cycles.
    assign bus.wr_rdy = (state_q == SERVE) & ~bus.mem_addr_vld;
    assign wr_fire    = bus.wr_vld & bus.wr_rdy;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = rd_idx;
        ram_wdata = '0;
        case (state_q)
            INIT: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = cnt_q;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_MAX) begin
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (bus.mem_addr_vld) begin
                    ram_en = 1'b1;
                end else if (wr_fire) begin
                    ram_en    = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = bus.wr_addr;
                    ram_wdata = bus.wr_data;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_zero_q <= 1'b0;
            oob_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s1_vld_q  <= bus.mem_addr_vld;
            // Sweep-time and out-of-range reads never see RAM contents.
            s1_zero_q <= (state_q == INIT) | oob_hit;
            oob_err_q <= oob_err_q | (bus.mem_addr_vld & oob_hit);
        end
    end

    sha_mem_array #(
        .AW (DEPTH_LOG2),
        .DW (SHA_WORD_W)
    ) u_array (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

`ifdef SHA_MEM_BYTESWAP_EN
    assign s1_word = sha_bswap32(ram_rdata);
`else
    assign s1_word = ram_rdata;
`endif

    assign s1_dat = s1_zero_q ? '0 : s1_word;

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            logic [SHA_WORD_W-1:0] hold_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_q <= '0;
                end else if (s1_vld_q) begin
                    hold_q <= s1_dat;
                end
            end

            assign bus.mem_data_vld = s1_vld_q;
            assign bus.mem_data     = s1_vld_q ? s1_dat : hold_q;
        end else begin : g_latn
            logic [READ_LATENCY:2]                 pv_q;
            logic [READ_LATENCY:2][SHA_WORD_W-1:0] pd_q;

            // Data stages load only with their valid so the output holds between responses.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pv_q <= '0;
                    pd_q <= '0;
                end else begin
                    pv_q[2] <= s1_vld_q;
                    if (s1_vld_q) begin
                        pd_q[2] <= s1_dat;
                    end
                    for (int k = 3; k <= READ_LATENCY; k++) begin
                        pv_q[k] <= pv_q[k-1];
                        if (pv_q[k-1]) begin
                            pd_q[k] <= pd_q[k-1];
                        end
                    end
                end
            end

            assign bus.mem_data_vld = pv_q[READ_LATENCY];
            assign bus.mem_data     = pd_q[READ_LATENCY];
        end
    endgenerate

    assign bus.init_done = (state_q == SERVE);
    assign bus.oob_err   = oob_err_q;

endmodule

// File: tb/tb_sha_mem_responder.sv
// Scoreboard bench for sha_mem_responder: directed reads/writes push expected responses, a monitor pops on mem_data_vld.
module tb_sha_mem_responder;

    localparam int DL  = 10;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha_mem_responder_if #(.DEPTH_LOG2(DL)) bus ();

    sha_mem_responder #(
        .DEPTH_LOG2   (DL),
        .READ_LATENCY (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef SHA_MEM_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every response must match the oldest outstanding request, LAT cycles after issue.
    always @(negedge clk) begin
        if (!rst && bus.mem_data_vld) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got data %h at cycle %0d, expected no response", bus.mem_data, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_data", bus.mem_data, mon_e.dat);
                check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc + LAT));
            end
        end
    end

    task automatic issue_read(input logic [31:0] addr, input logic [31:0] dat);
        bus.mem_addr_vld = 1'b1;
        bus.mem_addr     = addr;
        sb.push_back('{dat: dat, cyc: cyc});
        @(negedge clk);
        bus.mem_addr_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.mem_addr_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input logic [DL-1:0] a, input logic [31:0] d);
        int n;
        bus.wr_vld  = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        #1;
        n = 0;
        while (!bus.wr_rdy && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL wr_timeout: wr_rdy stayed 0 for %0d cycles, expected 1", n);
        end
        @(negedge clk);
        bus.wr_vld = 1'b0;
    endtask

    // Runs from reset release until init_done; optionally probes reads mid-sweep and on the last INIT cycle.
    task automatic run_init(input bit probe);
        int rise;
        int rdy_bad;
        rise    = -1;
        rdy_bad = 0;
        for (int k = 0; k < 2000; k++) begin
            if (probe && (k == 500 || k == (1 << DL) - 1)) begin
                bus.mem_addr_vld = 1'b1;
                bus.mem_addr     = 32'h14;
                sb.push_back('{dat: 32'h0, cyc: cyc});
            end else begin
                bus.mem_addr_vld = 1'b0;
            end
            @(negedge clk);
            if (bus.init_done) begin
                rise = k + 1;
                break;
            end
            if (bus.wr_rdy !== 1'b0) rdy_bad++;
        end
        bus.mem_addr_vld = 1'b0;
        check("init_done_rise_cycles", 32'(rise), 32'(1 << DL));
        check("wr_rdy_low_during_init", 32'(rdy_bad), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_addr_vld = 1'b0;
        bus.mem_addr     = '0;
        bus.wr_vld       = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        repeat (3) @(negedge clk);

        check("rst_mem_data_vld", {31'b0, bus.mem_data_vld}, 32'h0);
        check("rst_mem_data", bus.mem_data, 32'h0);
        check("rst_wr_rdy", {31'b0, bus.wr_rdy}, 32'h0);
        check("rst_init_done", {31'b0, bus.init_done}, 32'h0);
        check("rst_oob_err", {31'b0, bus.oob_err}, 32'h0);

        rst = 1'b0;
        run_init(1'b0);
        check("wr_rdy_serve_idle", {31'b0, bus.wr_rdy}, 32'h1);

        for (int i = 0; i < 16; i++) do_write(DL'(i), 32'(i));
        for (int i = 0; i < 16; i++) begin
            bus.mem_addr_vld = 1'b1;
            bus.mem_addr     = 32'(i * 4);
            sb.push_back('{dat: exp_word(32'(i)), cyc: cyc});
            @(negedge clk);
        end
        idle(4);

        // Host write held against three back-to-back reads of the same word.
        bus.wr_vld  = 1'b1;
        bus.wr_addr = DL'(5);
        bus.wr_data = 32'hDEAD_BEEF;
        for (int j = 0; j < 3; j++) begin
            bus.mem_addr_vld = 1'b1;
            bus.mem_addr     = 32'h14;
            sb.push_back('{dat: exp_word(32'h5), cyc: cyc});
            #1;
            check("wr_rdy_blocked_by_read", {31'b0, bus.wr_rdy}, 32'h0);
            @(negedge clk);
        end
        bus.mem_addr_vld = 1'b0;
        #1;
        check("wr_rdy_after_reads", {31'b0, bus.wr_rdy}, 32'h1);
        @(negedge clk);
        bus.wr_vld = 1'b0;
        issue_read(32'h14, exp_word(32'hDEAD_BEEF));
        idle(4);

        check("oob_err_before", {31'b0, bus.oob_err}, 32'h0);
        bus.mem_addr_vld = 1'b1;
        bus.mem_addr     = 32'h0000_1000;
        sb.push_back('{dat: 32'h0, cyc: cyc});
        #1;
        check("oob_err_same_cycle", {31'b0, bus.oob_err}, 32'h0);
        @(negedge clk);
        bus.mem_addr_vld = 1'b0;
        check("oob_err_next_cycle", {31'b0, bus.oob_err}, 32'h1);
        issue_read(32'h8000_0014, 32'h0);
        idle(6);
        check("oob_err_sticky", {31'b0, bus.oob_err}, 32'h1);

        do_write(DL'(7), 32'h6463_6261);
        issue_read(32'h1C, exp_word(32'h6463_6261));
        idle(4);
        check("mem_data_hold", bus.mem_data, exp_word(32'h6463_6261));

        // Reset with one read in the pipeline and another on the bus: both must vanish.
        bus.mem_addr_vld = 1'b1;
        bus.mem_addr     = 32'h14;
        @(negedge clk);
        bus.mem_addr     = 32'h1C;
        rst              = 1'b1;
        #1;
        bus.mem_addr_vld = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst2_mem_data_vld", {31'b0, bus.mem_data_vld}, 32'h0);
        end
        check("rst2_init_done", {31'b0, bus.init_done}, 32'h0);
        check("rst2_mem_data", bus.mem_data, 32'h0);
        check("rst2_oob_err", {31'b0, bus.oob_err}, 32'h0);
        rst = 1'b0;
        run_init(1'b1);

        issue_read(32'h14, 32'h0);
        issue_read(32'h1C, 32'h0);
        idle(6);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha_mem_responder.md
Name: sha_mem_responder

Overview:
- Memory-side responder for the SHA-256 message-fetch interface: it answers the word reads the chunk fetcher issues, so it sits on the other end of `mem_addr_vld`/`mem_addr` -> `mem_data_vld`/`mem_data`.
- Holds message data in an on-chip word RAM that a host fills through a write port with a ready handshake.
- Returns read data in request order after a fixed latency, with no backpressure on the read side.
- After reset it runs an initialisation sweep that zeroes the RAM.

Parameters:
- `DEPTH_LOG2`, default 10: log2 of the number of 32-bit words in the RAM.
- `READ_LATENCY`, default 2: cycles from request to response; legal range 1..4.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `mem_addr_vld`  in  1  read request strobe; one word per cycle; cannot be stalled
- `mem_addr`  in  32  byte address; bits [1:0] ignored
- `mem_data_vld`  out  1  read response strobe
- `mem_data`  out  32  read response word
- `wr_vld`  in  1  host write request
- `wr_rdy`  out  1  host write accepted when `wr_vld & wr_rdy`
- `wr_addr`  in  `DEPTH_LOG2`  word index to write
- `wr_data`  in  32  word to write
- `init_done`  out  1  high once the zeroing sweep has finished
- `oob_err`  out  1  sticky flag: an out-of-range read occurred

Behaviour:
- Reset values: `mem_data_vld`=0, `mem_data`=0, `wr_rdy`=0, `init_done`=0, `oob_err`=0, all pipeline valid bits=0, FSM=INIT, sweep counter=0. RAM contents are not reset.
- Reset asserted mid-operation: in-flight responses are discarded and no `mem_data_vld` pulse follows. After release the sweep restarts from word 0.
- FSM INIT:
  - Writes 0 to word `cnt` each cycle and increments `cnt`.
  - When `cnt` = 2^DEPTH_LOG2-1 is written, moves to SERVE.
  - INIT lasts exactly 2^DEPTH_LOG2 cycles; `init_done` rises on the first SERVE cycle.
- FSM SERVE:
  - Terminal state; it is left only by reset.
- Read path (both states):
  - A request is taken every cycle `mem_addr_vld`=1.
  - Word index = `mem_addr[DEPTH_LOG2+1:2]`.
  - `mem_data_vld` asserts exactly `READ_LATENCY` cycles after the request, for one cycle per request.
  - Back-to-back requests give back-to-back responses, in order.
- Read data rules:
  - During INIT, reads return 0; the sweep has priority on the RAM port.
  - In SERVE, reads return the RAM word.
  - A write in cycle N is visible to a read issued in cycle N+1 or later.
- Out of range:
  - Any of `mem_addr[31:DEPTH_LOG2+2]` nonzero means the response is still given with data 0, and `oob_err` sets one cycle after the request.
  - `oob_err` clears only on reset.
- Write path:
  - `wr_rdy` = (state==SERVE) & !`mem_addr_vld`, i.e. reads win the single RAM port.
  - `wr_rdy` is combinational from `mem_addr_vld`.
  - A write accepted in cycle N updates the RAM at the clock edge ending cycle N.
- Simultaneous events:
  - Read and host write in the same cycle: the write is not accepted, and the host holds `wr_vld`/`wr_addr`/`wr_data` stable.
  - Read on the last INIT cycle: returns 0.
- Data alignment:
  - `mem_data` holds its last value when `mem_data_vld`=0.
  - Consumers sample only on `mem_data_vld`.

Optional Feature:
- Macro: `SHA_MEM_BYTESWAP_EN`.
- Defined: `mem_data` is byte-reversed on the response path (byte 0 of the RAM word goes to bits [31:24]), so a host loading little-endian bytes yields the big-endian message words SHA-256 needs. Latency is unchanged.
- Undefined: the RAM word is returned unmodified.

Decomposition:
- `sha256_pkg` gains:
  - `SHA_WORD_W`=32
  - `SHA_MEM_DEPTH_LOG2_DEF`=10
  - `SHA_MEM_RD_LAT_DEF`=2
  - enum `sha_mem_state_e` {INIT, SERVE}
  - function `sha_bswap32`
- One sub-module, `sha_mem_array`: single-port synchronous RAM with one read/write port and 1-cycle read. The remaining `READ_LATENCY`-1 stages (valid bit plus out-of-range bit) live in `sha_mem_responder`.

Test Plan:
- Reset, then idle: `init_done` rises exactly 1024 cycles after reset release; `wr_rdy`=0 throughout INIT; no `mem_data_vld` pulse.
- After init, host writes words 0..15 = 32'h0000_0000..32'h0000_000F, then `mem_addr`=0x0,0x4,...,0x3C on 16 consecutive cycles -> 16 consecutive `mem_data_vld` pulses starting 2 cycles after the first request, data 0..F in order.
- `wr_vld` held with `wr_addr`=5, `wr_data`=32'hDEADBEEF while `mem_addr_vld` is high for 3 cycles -> `wr_rdy`=0 for those 3 cycles; the write lands on the 4th; a read of 0x14 issued the next cycle returns DEADBEEF.
- `mem_addr`=0x0000_1000 (out of range, depth 1024) -> response data 0 after 2 cycles; `oob_err`=1 one cycle after the request and stays high until reset.
- `rst` asserted while 2 reads are in flight -> no `mem_data_vld` appears; `init_done`=0; a word previously written as nonzero reads 0 after the new INIT.
- With `SHA_MEM_BYTESWAP_EN` defined: write 32'h64636261, read it back -> `mem_data`=32'h61626364.
